seq_bcd_display: RTL and testbench
==================================

Name: seq_bcd_display

Overview:
- Parametrised, sequential successor to the combinational binary-to-BCD/7-segment display path.
- Converts a WIDTH-bit two's-complement or unsigned value to DIGITS BCD digits using iterative double-dabble (shift-add-3), one bit per clock.
- Drives DIGITS seven-segment displays plus a sign indicator, with a start/busy/done handshake.
- Sits between the datapath result register and the board displays; outputs hold steady between conversions.

Parameters:
- WIDTH, 32, bit width of the input value (>= 4).
- DIGITS, 10, number of BCD digits/displays (>= 1).
- SIGNED, 1, 1 = value is two's complement and the magnitude is displayed with neg; 0 = value is unsigned and neg is always 0.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  WIDTH  value to convert; sampled on the accepting edge.
- active_low  input  1  1 = segment outputs inverted (common-anode); combinational, may change at any time.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new results are valid.
- neg  output  1  sign of the last converted value.
- overflow  output  1  last result exceeded DIGITS decimal digits.
- bcd  output  4*DIGITS  last result; digit i is bcd[4i+3:4i], with digit 0 as the units digit.
- segs  output  7*DIGITS  segments for digit i are segs[7i+6:7i], ordered gfedcba.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, neg=0, overflow=0, bcd=0, FSM in IDLE, bit counter=0.
  - segs reflects bcd=0, so every display shows "0", subject to active_low and the optional feature.
- FSM states: IDLE, SHIFT.
  - IDLE: if start=1 at edge E0:
    - Latch magnitude into the shift register. If SIGNED=1 and value[WIDTH-1]=1, magnitude = -value (WIDTH-bit) and sign is latched as 1; otherwise magnitude = value and sign is latched as 0.
    - Clear the scratch BCD register, set counter=WIDTH, go to SHIFT. busy=1 from E0.
  - SHIFT: at each edge, every scratch digit >= 5 gets +3, then {scratch BCD, magnitude} shifts left 1 and counter decrements.
    - A 1 shifted out of the top digit sets a sticky overflow scratch bit.
    - On the edge where counter reaches 0 (edge E_WIDTH): bcd, neg and overflow update together, busy goes to 0, done=1 for exactly one cycle, and the FSM returns to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after the accepting edge. Back-to-back: start may be accepted on the edge where done is asserted, giving a throughput of one conversion per WIDTH+1 cycles.
- start while busy: ignored and not queued. value changes during SHIFT have no effect.
- Outputs bcd, neg and overflow change only at E_WIDTH and hold otherwise, so the displays never show partial results.
- Most negative value with SIGNED=1: the magnitude 2^(WIDTH-1) fits in WIDTH bits unsigned, so conversion is exact.
- Overflow: if DIGITS is too small, bcd holds the low DIGITS digits (modulo 10^DIGITS) and overflow=1.
- Reset asserted mid-conversion: the conversion is aborted, all outputs go to their reset values on that edge, and no done pulse is issued.
- Segment encoding (active-high, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10-15 are unreachable; they decode as blank (00).
  - active_low=1 inverts all bits of segs.
- segs is combinational from the registered bcd and active_low only.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: zero digits above the most significant non-zero digit are blanked (all segments off: 00 active-high, 7F active-low). Digit 0 is never blanked, so value 0 shows a single "0". bcd is unaffected.
- Not defined: all DIGITS displays always show their digit, including leading zeros.

Test Plan:
- Reset, then start with value=0: done exactly 32 cycles after the accepting edge; bcd=0x0000000000, neg=0, overflow=0, segs digit0=3F.
- value=12345678 (SIGNED=1): bcd=0x0012345678, neg=0; digit0 segs=7F, digit7 segs=06; with active_low=1, digit0 segs=00.
- value=32'hFFFFFFFF: with SIGNED=1, expect neg=1, bcd=1. In a SIGNED=0 instance, expect bcd=0x4294967295, neg=0.
- value=32'h80000000 with SIGNED=1: neg=1, bcd=0x2147483648, overflow=0.
- DIGITS=3, WIDTH=16 instance, value=1234: bcd=0x234, overflow=1. Pulsing start at mid-conversion cycle 5 is ignored: one done pulse only, and results are unchanged.
- Assert reset at cycle 10 of a conversion of 999: busy=0, bcd=0, and no done pulse. A following conversion of 999 yields bcd=0x999. With LEADING_ZERO_BLANK_EN defined, digits 3..9 read 00.

Source files
------------

// File: rtl/seq_bcd_display_if.sv
// Handshake and display bus for seq_bcd_display: start/value request side,
// busy/done status and the registered BCD plus decoded segment outputs.
interface seq_bcd_display_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  active_low;
    logic                  busy;
    logic                  done;
    logic                  neg;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   segs;

    modport master (
        output start, value, active_low,
        input  busy, done, neg, overflow, bcd, segs
    );

    modport slave (
        input  start, value, active_low,
        output busy, done, neg, overflow, bcd, segs
    );
endinterface

// File: rtl/seq_bcd_display.sv
// Sequential binary-to-BCD (double-dabble, one bit per clock) with 7-segment decode.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | shift-add-3 in progress, count bits remaining
module seq_bcd_display #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 1
) (
    input  logic               clock,
    input  logic               reset,
    seq_bcd_display_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   scratch_nxt;
    logic            sign_s;
    logic            ovf_s;
    logic            ovf_nxt;
    logic [CW-1:0]   count;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // A carry out of the top digit means the value needs more than DIGITS digits.
    assign scratch_nxt = {adj[BW-2:0], mag[WIDTH-1]};
    assign ovf_nxt     = ovf_s | adj[BW-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            mag          <= '0;
            scratch      <= '0;
            sign_s       <= 1'b0;
            ovf_s        <= 1'b0;
            count        <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.neg      <= 1'b0;
            bus.overflow <= 1'b0;
            bus.bcd      <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if ((SIGNED != 0) && bus.value[WIDTH-1]) begin
                            mag    <= -bus.value;
                            sign_s <= 1'b1;
                        end else begin
                            mag    <= bus.value;
                            sign_s <= 1'b0;
                        end
                        scratch  <= '0;
                        ovf_s    <= 1'b0;
                        count    <= CW'(WIDTH);
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    mag     <= {mag[WIDTH-2:0], 1'b0};
                    ovf_s   <= ovf_nxt;
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        bus.bcd      <= scratch_nxt;
                        bus.neg      <= sign_s;
                        bus.overflow <= ovf_nxt;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    logic [3:0] dig;
    logic [6:0] seg;
`ifdef LEADING_ZERO_BLANK_EN
    logic       lead;
`endif

    always_comb begin
        bus.segs = '0;
        dig      = '0;
        seg      = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lead     = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = bus.bcd[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            // Walk down from the top digit; digit 0 always shows.
            if (lead && (i != 0) && (dig == 4'd0)) begin
                seg = 7'h00;
            end else begin
                lead = 1'b0;
                seg  = enc(dig);
            end
`else
            seg = enc(dig);
`endif
            bus.segs[7*i +: 7] = bus.active_low ? ~seg : seg;
        end
    end
endmodule

// File: tb/tb_seq_bcd_display.sv
// Scoreboard bench for seq_bcd_display: three instances (signed 32/10, unsigned 32/10,
// signed 16/3) checked against an arithmetic decimal model.
module tb_seq_bcd_display;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [39:0] bcd;
        logic        neg;
        logic        ovf;
        logic [31:0] due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    seq_bcd_display_if #(.WIDTH(32), .DIGITS(10)) ifa();
    seq_bcd_display_if #(.WIDTH(32), .DIGITS(10)) ifb();
    seq_bcd_display_if #(.WIDTH(16), .DIGITS(3))  ifc();

    assign ifb.start      = ifa.start;
    assign ifb.value      = ifa.value;
    assign ifb.active_low = ifa.active_low;

    seq_bcd_display #(.WIDTH(32), .DIGITS(10), .SIGNED(1)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
    seq_bcd_display #(.WIDTH(32), .DIGITS(10), .SIGNED(0)) dut_b (.clock(clock), .reset(reset), .bus(ifb));
    seq_bcd_display #(.WIDTH(16), .DIGITS(3),  .SIGNED(1)) dut_c (.clock(clock), .reset(reset), .bus(ifc));

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal digits by plain division; overflow when the magnitude needs more digits.
    function automatic exp_t model(input logic [31:0] v, input int w, input int d, input bit sg);
        exp_t e;
        longint unsigned m;
        longint unsigned lim;
        e = '0;
        m = 64'(v);
        if (sg && v[w-1]) begin
            m = (64'd1 << w) - m;
            e.neg = 1'b1;
        end
        lim = 1;
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = 4'((m / lim) % 10);
            lim = lim * 10;
        end
        e.ovf = (m >= lim);
        return e;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [69:0] segs_model(input logic [39:0] b, input int d, input bit al);
        logic [69:0] r;
        logic [6:0]  s;
        r = '0;
        for (int i = 0; i < d; i++) begin
            s = seg7(b[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && (b >> (4*i)) == 40'd0) s = 7'h00;
`endif
            r[7*i +: 7] = al ? ~s : s;
        end
        return r;
    endfunction

    task automatic check_out(input string tag, input exp_t e, input logic [39:0] bcd,
                             input logic neg, input logic ovf, input logic [69:0] segs,
                             input int d, input bit al);
        chk({tag, "_bcd"},     70'(bcd),  70'(e.bcd));
        chk({tag, "_neg"},     70'(neg),  70'(e.neg));
        chk({tag, "_overflow"}, 70'(ovf), 70'(e.ovf));
        chk({tag, "_segs"},    segs,      segs_model(e.bcd, d, al));
        chk({tag, "_latency"}, 70'(cyc),  70'(e.due));
    endtask

    always @(negedge clock) begin
        if (ifa.done) begin
            chk("a_done_expected", 70'(qa.size() > 0), 70'd1);
            if (qa.size() > 0)
                check_out("a", qa.pop_front(), ifa.bcd, ifa.neg, ifa.overflow, 70'(ifa.segs), 10, ifa.active_low);
        end
        if (ifb.done) begin
            chk("b_done_expected", 70'(qb.size() > 0), 70'd1);
            if (qb.size() > 0)
                check_out("b", qb.pop_front(), ifb.bcd, ifb.neg, ifb.overflow, 70'(ifb.segs), 10, ifb.active_low);
        end
        if (ifc.done) begin
            chk("c_done_expected", 70'(qc.size() > 0), 70'd1);
            if (qc.size() > 0)
                check_out("c", qc.pop_front(), 40'(ifc.bcd), ifc.neg, ifc.overflow, 70'(ifc.segs), 3, ifc.active_low);
        end
    end

    task automatic go_ab(input logic [31:0] v, input bit al);
        exp_t e;
        @(negedge clock);
        for (int k = 0; k < 100 && ifa.busy; k++) @(negedge clock);
        ifa.value      = v;
        ifa.active_low = al;
        ifa.start      = 1'b1;
        @(posedge clock);
        #1;
        ifa.start = 1'b0;
        chk("ab_busy_after_accept", 70'(ifa.busy & ifb.busy), 70'd1);
        e = model(v, 32, 10, 1'b1);
        e.due = 32'(cyc + 32);
        qa.push_back(e);
        e = model(v, 32, 10, 1'b0);
        e.due = 32'(cyc + 32);
        qb.push_back(e);
    endtask

    task automatic go_c(input logic [15:0] v, input bit al);
        exp_t e;
        @(negedge clock);
        for (int k = 0; k < 100 && ifc.busy; k++) @(negedge clock);
        ifc.value      = v;
        ifc.active_low = al;
        ifc.start      = 1'b1;
        @(posedge clock);
        #1;
        ifc.start = 1'b0;
        chk("c_busy_after_accept", 70'(ifc.busy), 70'd1);
        e = model(32'(v), 16, 3, 1'b1);
        e.due = 32'(cyc + 16);
        qc.push_back(e);
    endtask

    task automatic wait_idle();
        @(negedge clock);
        for (int k = 0; k < 100 && (ifa.busy || ifc.busy); k++) @(negedge clock);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [31:0] dv [8];
        reset = 1'b1;
        ifa.start = 1'b0; ifa.value = '0; ifa.active_low = 1'b0;
        ifc.start = 1'b0; ifc.value = '0; ifc.active_low = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_a_busy", 70'(ifa.busy), 70'd0);
        chk("rst_a_done", 70'(ifa.done), 70'd0);
        chk("rst_a_bcd",  70'(ifa.bcd),  70'd0);
        chk("rst_a_neg",  70'(ifa.neg),  70'd0);
        chk("rst_a_ovf",  70'(ifa.overflow), 70'd0);
        chk("rst_a_segs", 70'(ifa.segs), segs_model(40'd0, 10, 1'b0));
        chk("rst_b_bcd",  70'(ifb.bcd),  70'd0);
        chk("rst_c_busy", 70'(ifc.busy), 70'd0);
        chk("rst_c_segs", 70'(ifc.segs), segs_model(40'd0, 3, 1'b0));
        reset = 1'b0;

        dv[0] = 32'd0;        dv[1] = 32'd12345678; dv[2] = 32'hFFFF_FFFF; dv[3] = 32'h8000_0000;
        dv[4] = 32'd1;        dv[5] = 32'd10;       dv[6] = 32'h7FFF_FFFF; dv[7] = 32'd100;
        for (int i = 0; i < 8; i++) go_ab(dv[i], 1'(i % 2 == 1 && i > 2));

        // Segment polarity is combinational on the held result.
        wait_idle();
        ifa.active_low = 1'b1;
        #1;
        chk("a_segs_active_low", 70'(ifa.segs), segs_model(model(32'd100, 32, 10, 1'b1).bcd, 10, 1'b1));
        ifa.active_low = 1'b0;
        #1;
        chk("a_segs_active_high", 70'(ifa.segs), segs_model(model(32'd100, 32, 10, 1'b1).bcd, 10, 1'b0));

        for (int i = 0; i < 16; i++) begin
            go_ab((i % 2 == 0) ? $urandom : 32'($urandom_range(0, 99999)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        // Reset mid-conversion: aborted, no done pulse.
        wait_idle();
        go_ab(32'd999, 1'b0);
        repeat (9) @(posedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_a_busy", 70'(ifa.busy), 70'd0);
        chk("midrst_a_bcd",  70'(ifa.bcd),  70'd0);
        chk("midrst_a_done", 70'(ifa.done), 70'd0);
        chk("midrst_b_bcd",  70'(ifb.bcd),  70'd0);
        chk("midrst_a_neg",  70'(ifa.neg),  70'd0);
        qa.delete();
        qb.delete();
        reset = 1'b0;
        repeat (40) @(negedge clock);
        go_ab(32'd999, 1'b0);
        go_ab(32'd999, 1'b1);

        // Small instance: overflow, start ignored while busy.
        wait_idle();
        go_c(16'd1234, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        ifc.value = 16'd7;
        ifc.start = 1'b1;
        @(posedge clock);
        #1;
        ifc.start = 1'b0;
        chk("c_busy_during_ignored_start", 70'(ifc.busy), 70'd1);
        go_c(16'd999, 1'b0);
        go_c(16'hFFFF, 1'b1);
        go_c(16'h8000, 1'b0);
        go_c(16'd0, 1'b0);
        for (int i = 0; i < 10; i++) go_c(16'($urandom), 1'($urandom_range(0, 1)));

        wait_idle();
        repeat (40) @(negedge clock);
        chk("a_queue_drained", 70'(qa.size()), 70'd0);
        chk("b_queue_drained", 70'(qb.size()), 70'd0);
        chk("c_queue_drained", 70'(qc.size()), 70'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
